// File: rtl/echo_client_if.sv
`default_nettype none
// ============================================================================
//  Module      : echo_client_if
//  Description : Say/heard handshake bundle between the echo client and the
//                echo server it exercises.
//  Revision    : 1.0 - initial release
// ============================================================================
interface echo_client_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  say__ENA;
    logic [DATA_WIDTH-1:0] say_v;
    logic                  say__RDY;
    logic                  heard__ENA;
    logic [DATA_WIDTH-1:0] heard_v;
    logic                  heard__RDY;

    // Client side: issues say requests and accepts heard indications
    modport master (
        output say__ENA, say_v, heard__RDY,
        input  say__RDY, heard__ENA, heard_v
    );

    // Server side: accepts say requests and delivers heard indications
    modport slave (
        input  say__ENA, say_v, heard__RDY,
        output say__RDY, heard__ENA, heard_v
    );
endinterface
`default_nettype wire

// File: rtl/echo_client.sv
`default_nettype none
// ============================================================================
//  Module      : echo_client
//  Description : Traffic generator/checker for an echo server. Sends a run of
//                incrementing payloads, bounds the number in flight, checks
//                every echoed payload in order and aborts on a stalled server.
//  Revision    : 1.0 - initial release
// ============================================================================
module echo_client #(
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT         = 1024
) (
    input  wire logic                  CLK,
    input  wire logic                  nRST,
    input  wire logic                  start__ENA,
    input  wire logic [15:0]           start_count,
    input  wire logic [DATA_WIDTH-1:0] start_base,
    output logic                       start__RDY,
    echo_client_if.master              srv,
    output logic                       done,
    output logic                       pass,
    output logic                       timeout,
    output logic [15:0]                err_count,
    output logic [15:0]                rcvd_count
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [OW-1:0] c_max_out = OW'(MAX_OUTSTANDING);
    localparam logic [TW-1:0] c_timeout = TW'(TIMEOUT);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]            r_state;
    logic [15:0]           r_count;
    logic [DATA_WIDTH-1:0] r_base;
    logic [15:0]           r_sent;
    logic [15:0]           r_rcvd;
    logic [15:0]           r_err;
    logic [OW-1:0]         r_outstanding;
    logic [TW-1:0]         r_timer;
    logic                  r_timeout;

    logic                  w_start;
    logic                  w_run;
    logic                  w_say;
    logic                  w_heard_rdy;
    logic                  w_heard;
    logic [DATA_WIDTH-1:0] w_expect;
    logic                  w_mismatch;
    logic [15:0]           w_rcvd_next;
    logic [TW-1:0]         w_timer_next;
    logic                  w_stalled;
    logic                  w_timer_hit;

    // Handshake decode; say/heard are same-cycle functions of the current state
    always_comb begin
        w_start      = start__ENA & start__RDY;
        w_run        = (r_state == S_RUN);
        w_say        = w_run & (r_sent < r_count) & (r_outstanding < c_max_out) & srv.say__RDY;
        w_heard_rdy  = w_run & (r_outstanding != '0);
        w_heard      = srv.heard__ENA & w_heard_rdy;
        // Echoes come back in order, so the expected payload tracks the receive count
        w_expect     = r_base + DATA_WIDTH'(r_rcvd);
        w_mismatch   = w_heard & (srv.heard_v != w_expect);
        w_rcvd_next  = r_rcvd + 16'd1;
        w_timer_next = r_timer + TW'(1);
        w_stalled    = w_heard_rdy & ~w_heard;
        w_timer_hit  = w_stalled & (w_timer_next == c_timeout);
    end

    // Run control: start, completion on final echo, abort on stall timeout
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_base    <= '0;
            r_timeout <= 1'b0;
        end else if (w_start) begin
            r_count   <= start_count;
            r_base    <= start_base;
            r_timeout <= 1'b0;
            r_state   <= (start_count == 16'd0) ? S_DONE : S_RUN;
        end else if (w_run) begin
            if (w_heard && (w_rcvd_next == r_count)) begin
                r_state <= S_DONE;
            end else if (w_timer_hit) begin
                r_state   <= S_DONE;
                r_timeout <= 1'b1;
            end
        end
    end

    // Transaction bookkeeping: sent/received/error counts and in-flight depth
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_sent        <= '0;
            r_rcvd        <= '0;
            r_err         <= '0;
            r_outstanding <= '0;
        end else if (w_start) begin
            r_sent        <= '0;
            r_rcvd        <= '0;
            r_err         <= '0;
            r_outstanding <= '0;
        end else begin
            if (w_say) begin
                r_sent <= r_sent + 16'd1;
            end
            if (w_heard) begin
                r_rcvd <= w_rcvd_next;
            end
            if (w_mismatch && (r_err != 16'hFFFF)) begin
                r_err <= r_err + 16'd1;
            end
            // Simultaneous say and heard cancel out
            case ({w_say, w_heard})
                2'b10:   r_outstanding <= r_outstanding + OW'(1);
                2'b01:   r_outstanding <= r_outstanding - OW'(1);
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    // Stall timer: counts waiting cycles, restarts on any echo or when nothing is in flight
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_timer <= '0;
        end else if (w_start) begin
            r_timer <= '0;
        end else if (w_stalled) begin
            r_timer <= w_timer_next;
        end else begin
            r_timer <= '0;
        end
    end

    // Output decode
    always_comb begin
        start__RDY     = (r_state == S_IDLE) | (r_state == S_DONE);
        srv.say__ENA   = w_say;
        srv.say_v      = r_base + DATA_WIDTH'(r_sent);
        srv.heard__RDY = w_heard_rdy;
        done           = (r_state == S_DONE);
        pass           = (r_state == S_DONE) & (r_err == 16'd0) & ~r_timeout;
        timeout        = r_timeout;
        err_count      = r_err;
        rcvd_count     = r_rcvd;
    end

endmodule
`default_nettype wire

// File: tb/tb_echo_client.sv
`default_nettype none
// ============================================================================
//  Module      : tb_echo_client
//  Description : Scoreboard bench for echo_client with a loopback echo server
//                model, payload corruption, withheld echoes and reset abort.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_echo_client;

    localparam int DW = 32;

    typedef struct packed {
        logic [15:0] err;
        logic [15:0] rcvd;
        logic        pass;
        logic        to;
    } res_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start__ENA = 1'b0;
    logic [15:0]   start_count = '0;
    logic [DW-1:0] start_base = '0;
    logic          start__RDY;
    logic          done, pass, timeout;
    logic [15:0]   err_count, rcvd_count;

    echo_client_if #(.DATA_WIDTH(DW)) srv ();

    echo_client #(
        .DATA_WIDTH      (DW),
        .MAX_OUTSTANDING (4),
        .TIMEOUT         (16)
    ) dut (
        .CLK         (clk),
        .nRST        (rst_n),
        .start__ENA  (start__ENA),
        .start_count (start_count),
        .start_base  (start_base),
        .start__RDY  (start__RDY),
        .srv         (srv),
        .done        (done),
        .pass        (pass),
        .timeout     (timeout),
        .err_count   (err_count),
        .rcvd_count  (rcvd_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    logic [DW-1:0] say_exp_q[$];
    res_t          res_q[$];
    logic [DW-1:0] srv_q[$];

    bit   loop_en     = 1'b1;
    int   corrupt_idx = -1;
    int   hcnt        = 0;
    int   say_pulses  = 0;
    int   say_cyc     = 0;
    int   done_cyc    = 0;
    logic done_q      = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_res(input logic [15:0] e, input logic [15:0] r, input logic p, input logic t);
        res_t x;
        x.err  = e;
        x.rcvd = r;
        x.pass = p;
        x.to   = t;
        res_q.push_back(x);
    endtask

    // Say monitor: every issued request must match the next expected payload
    always @(negedge clk) begin : mon_say
        if (srv.say__ENA) begin
            say_pulses++;
            say_cyc = cyc;
            if (say_exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_say: got say_v %0h expected no request", srv.say_v);
            end else begin
                check("say_v", 64'(srv.say_v), 64'(say_exp_q.pop_front()));
            end
        end
    end

    // Completion monitor: on each rising done compare the run result
    always @(negedge clk) begin : mon_done
        res_t r;
        if (done && !done_q) begin
            done_cyc = cyc;
            if (res_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got done=1 expected no completion");
            end else begin
                r = res_q.pop_front();
                check("result{err,rcvd,pass,timeout}",
                      64'({err_count, rcvd_count, pass, timeout}), 64'(r));
            end
        end
        done_q = done;
    end

    // Echo server model: in-order loopback, optional corruption of one echo
    always @(negedge clk) begin : server
        if (!rst_n) begin
            srv_q.delete();
            srv.heard__ENA = 1'b0;
            srv.heard_v    = '0;
        end else begin
            if (srv.heard__ENA && srv_q.size() > 0) begin
                void'(srv_q.pop_front());
                hcnt++;
            end
            srv.heard__ENA = 1'b0;
            if (loop_en && srv_q.size() > 0 && srv.heard__RDY) begin
                srv.heard__ENA = 1'b1;
                srv.heard_v    = (hcnt == corrupt_idx) ? 32'h0000_DEAD : srv_q[0];
            end
            if (srv.say__ENA) srv_q.push_back(srv.say_v);
        end
    end

    task automatic start_run(input logic [15:0] cnt, input logic [DW-1:0] b);
        @(posedge clk);
        #1;
        check("start_rdy_before_start", 64'(start__RDY), 64'd1);
        srv_q.delete();
        hcnt        = 0;
        say_pulses  = 0;
        start__ENA  = 1'b1;
        start_count = cnt;
        start_base  = b;
        @(posedge clk);
        #1;
        start__ENA  = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        int k = 0;
        while (!done && k < bound) begin
            @(negedge clk);
            k++;
        end
        check("done_reached", 64'(done), 64'd1);
        repeat (2) @(negedge clk);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        srv.say__RDY = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outputs", 64'({done, pass, timeout, srv.say__ENA, srv.heard__RDY, err_count, rcvd_count}), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("start_rdy_after_reset", 64'(start__RDY), 64'd1);

        // Plain loopback
        say_exp_q.push_back(32'h10);
        say_exp_q.push_back(32'h11);
        say_exp_q.push_back(32'h12);
        push_res(16'd0, 16'd3, 1'b1, 1'b0);
        start_run(16'd3, 32'h10);
        wait_done(50);

        // Payload wraps past 2^32
        say_exp_q.push_back(32'hFFFF_FFFE);
        say_exp_q.push_back(32'hFFFF_FFFF);
        say_exp_q.push_back(32'h0);
        say_exp_q.push_back(32'h1);
        push_res(16'd0, 16'd4, 1'b1, 1'b0);
        start_run(16'd4, 32'hFFFF_FFFE);
        wait_done(50);

        // Second echo corrupted
        corrupt_idx = 1;
        say_exp_q.push_back(32'h100);
        say_exp_q.push_back(32'h101);
        push_res(16'd1, 16'd2, 1'b0, 1'b0);
        start_run(16'd2, 32'h100);
        wait_done(50);
        corrupt_idx = -1;

        // Echoes withheld: in-flight window limits requests
        loop_en = 1'b0;
        for (int i = 0; i < 4; i++) say_exp_q.push_back(32'h200 + 32'(i));
        start_run(16'd6, 32'h200);
        repeat (12) @(negedge clk);
        check("window_pulses", 64'(say_pulses), 64'd4);
        check("heard_rdy_withheld", 64'(srv.heard__RDY), 64'd1);
        check("start_rdy_in_run", 64'(start__RDY), 64'd0);
        say_exp_q.push_back(32'h204);
        say_exp_q.push_back(32'h205);
        push_res(16'd0, 16'd6, 1'b1, 1'b0);
        loop_en = 1'b1;
        wait_done(50);
        check("window_total_pulses", 64'(say_pulses), 64'd6);

        // Stalled server: abort after the idle limit
        loop_en = 1'b0;
        say_exp_q.push_back(32'h300);
        push_res(16'd0, 16'd0, 1'b0, 1'b1);
        start_run(16'd1, 32'h300);
        wait_done(40);
        check("timeout_latency", 64'(done_cyc - say_cyc), 64'd17);
        check("done_quiet", 64'({srv.say__ENA, srv.heard__RDY}), 64'd0);
        loop_en = 1'b1;

        // Reset in the middle of a run
        say_exp_q.push_back(32'h400);
        say_exp_q.push_back(32'h401);
        start_run(16'd5, 32'h400);
        begin
            int k = 0;
            while (say_pulses < 2 && k < 20) begin
                @(posedge clk);
                #1;
                k++;
            end
        end
        rst_n = 1'b0;
        #1;
        check("reset_midrun_outputs", 64'({done, pass, timeout, srv.say__ENA, srv.heard__RDY, err_count, rcvd_count}), 64'd0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("start_rdy_post_release", 64'(start__RDY), 64'd1);
        check("no_say_after_reset", 64'(say_pulses), 64'd2);

        // Zero-length run completes immediately
        push_res(16'd0, 16'd0, 1'b1, 1'b0);
        start_run(16'd0, 32'h500);
        check("zero_count_done_pass", 64'({done, pass}), 64'd3);
        wait_done(1);

        check("say_queue_drained", 64'(say_exp_q.size()), 64'd0);
        check("result_queue_drained", 64'(res_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/echo_client.md
ECHO_CLIENT -- requirements
Module: echo_client

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of say/heard payload.
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 4, max requests sent but not yet heard (1..15).
REQ-003 SHALL have parameter TIMEOUT, default 1024, idle cycles with outstanding>0 before abort.
REQ-004 CLK  input  1  single clock; all state on rising edge.
REQ-005 nRST  input  1  reset, asynchronous and active-low.
REQ-006 start__ENA  input  1  start test run; asserted only when start__RDY=1.
REQ-007 start_count  input  16  number of say requests in the run.
REQ-008 start_base  input  DATA_WIDTH  first payload value.
REQ-009 start__RDY  output  1  high in IDLE or DONE.
REQ-010 say__ENA  output  1  issue one say request to echo server.
REQ-011 say_v  output  DATA_WIDTH  request payload.
REQ-012 say__RDY  input  1  echo server can accept say.
REQ-013 heard__ENA  input  1  echo server delivers one indication; asserted only when heard__RDY=1.
REQ-014 heard_v  input  DATA_WIDTH  indication payload.
REQ-015 heard__RDY  output  1  client can accept heard.
REQ-016 done  output  1  run complete (state DONE).
REQ-017 pass  output  1  done with zero errors and no timeout.
REQ-018 timeout  output  1  run ended by TIMEOUT.
REQ-019 err_count  output  16  payload mismatches this run.
REQ-020 rcvd_count  output  16  indications accepted this run.

Function
REQ-021 States SHALL be IDLE, RUN, DONE; IDLE after reset.
REQ-022 On start__ENA (IDLE or DONE): latch count/base, clear sent, rcvd_count, err_count, outstanding, idle timer, timeout; go RUN; if start_count=0 go DONE directly.
REQ-023 say__ENA SHALL = RUN & sent<count & outstanding<MAX_OUTSTANDING & say__RDY (combinational, same-cycle).
REQ-024 say_v SHALL = base + sent, modulo 2^DATA_WIDTH (wrap, no carry out).
REQ-025 Each say__ENA cycle SHALL increment sent and outstanding.
REQ-026 heard__RDY SHALL = RUN & outstanding!=0.
REQ-027 Each heard__ENA cycle SHALL compare heard_v with base + rcvd_count (mod 2^DATA_WIDTH); mismatch increments err_count, saturating at 16'hFFFF; rcvd_count increments; outstanding decrements.
REQ-028 say and heard in same cycle SHALL leave outstanding unchanged and update sent and rcvd_count both.
REQ-029 RUN→DONE on the edge where rcvd_count becomes count; done high the following cycle.
REQ-030 Idle timer SHALL count cycles in RUN with outstanding>0 and no heard__ENA; cleared on any heard__ENA or when outstanding=0.
REQ-031 Timer reaching TIMEOUT SHALL set timeout=1 and go DONE; outstanding requests abandoned.
REQ-032 pass SHALL = DONE & err_count=0 & !timeout.
REQ-033 In DONE, say__ENA and heard__RDY SHALL be 0; counters hold until next start.
REQ-034 start__ENA SHALL be ignored in RUN (start__RDY=0).

Reset
REQ-035 nRST low SHALL asynchronously force IDLE and zero all registers; outputs done, pass, timeout, say__ENA, heard__RDY, err_count, rcvd_count = 0.
REQ-036 nRST low mid-run SHALL abandon the run; no say__ENA after reset until a new start.
REQ-037 start__RDY SHALL be 1 from first cycle after reset deassertion.

Verification
REQ-038 count=3, base=0x10, echo server loopback -> say_v 0x10,0x11,0x12; done, pass=1, err_count=0, rcvd_count=3.
REQ-039 say__RDY held 1, heard withheld -> exactly MAX_OUTSTANDING (4) say__ENA pulses, then say__ENA=0 until a heard.
REQ-040 base=0xFFFFFFFE, count=4, loopback -> say_v 0xFFFFFFFE,0xFFFFFFFF,0x0,0x1; pass=1.
REQ-041 count=2, second heard_v corrupted to 0xDEAD -> done, err_count=1, pass=0.
REQ-042 count=1, say accepted, heard never sent, TIMEOUT=16 -> 16 idle cycles later done=1, timeout=1, pass=0.
REQ-043 nRST pulsed low after 2 of 5 sends -> all outputs 0 immediately, IDLE, start__RDY=1 post-release; count=0 start -> done, pass=1 next cycle.
